vga_timing_mixer: RTL

VGA_TIMING_MIXER -- requirements
Module: vga_timing_mixer

---
 rtl/vga_timing_mixer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_mixer.sv
// VGA raster timing generator with a two-layer colour mixer and a three-stage pixel pipeline.
// Optional white frame border when VGA_MIXER_BORDER_EN is defined.
module vga_timing_mixer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       enable,
  output logic       frame_start,
  input  logic [2:0] bg_red,
  input  logic [2:0] bg_green,
  input  logic [1:0] bg_blue,
  input  logic [2:0] fg_red,
  input  logic [2:0] fg_green,
  input  logic [1:0] fg_blue,
  input  logic       fg_layer,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue,
  output logic       vga_hsync,
  output logic       vga_vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Stage 0: raster counters
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync0, vsync0;

  // Stage 1: timing aligned with the layer inputs, which arrive one clock after stage 0
  logic       en1_q, hs1_q, vs1_q;

  // Stage 2: registered outputs
  logic [2:0] red_q, red_d;
  logic [2:0] green_q, green_d;
  logic [1:0] blue_q, blue_d;
  logic       hs2_q, vs2_q;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
  end

  assign enable      = (hcount_q < H_VIS) && (vcount_q < V_VIS);
  assign frame_start = (hcount_q == '0) && (vcount_q == '0);
  assign hsync0      = !((hcount_q >= HS_START) && (hcount_q <= HS_END));
  assign vsync0      = !((vcount_q >= VS_START) && (vcount_q <= VS_END));

`ifdef VGA_MIXER_BORDER_EN
  logic border0, border1_q;

  assign border0 = enable && ((hcount_q == '0) || (hcount_q == 10'(H_VISIBLE - 1)) ||
                              (vcount_q == '0) || (vcount_q == 10'(V_VISIBLE - 1)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) border1_q <= 1'b0;
    else          border1_q <= border0;
  end
`endif

  // Layer inputs are only looked at while the stage-1 pixel is visible.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (en1_q) begin
      if (fg_layer) begin
        red_d   = fg_red;
        green_d = fg_green;
        blue_d  = fg_blue;
      end else begin
        red_d   = bg_red;
        green_d = bg_green;
        blue_d  = bg_blue;
      end
    end
`ifdef VGA_MIXER_BORDER_EN
    if (border1_q) begin
      red_d   = 3'b111;
      green_d = 3'b111;
      blue_d  = 2'b11;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      en1_q    <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      en1_q    <= enable;
      hs1_q    <= hsync0;
      vs1_q    <= vsync0;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign vga_red   = red_q;
  assign vga_green = green_q;
  assign vga_blue  = blue_q;
  assign vga_hsync = hs2_q;
  assign vga_vsync = vs2_q;

endmodule
